avmm_paged_fill_verify: RTL and testbench
=========================================

Name: avmm_paged_fill_verify

Overview:
- Synthesizable Avalon-MM master engine for paged windowed memories.
- The target memory is reached through two regions: a page-select CSR, and a data window of PAGE_BYTES.
- The engine fills the memory with a reproducible LFSR pattern, reads it back, compares, and reports pass/fail with an error count.
- It sits beside the PCIe endpoint on the same Avalon-MM interconnect, so memory self-test runs at line rate instead of through BFM BAR accesses.

Parameters:
- DW, 64, data width in bits; multiple of 32, at most 256.
- AW, 16, byte-address width.
- PAGE_BYTES, 128, window size in bytes; power of two, at least DW/8.
- PAGE_COUNT, 4, number of pages; power of two.
- PAGE_REG_ADDR, 'h10, byte address of the page-select register.
- WIN_BASE, 'h1000, byte address of window word 0; aligned to PAGE_BYTES.

Ports:
- clk_in  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle start pulse; ignored while busy.
- mode  in  2  sampled at start. 1 = fill, 2 = verify, 3 = fill then verify, 0 = no-op (done next cycle, pass=1).
- seed  in  32  LFSR seed, sampled at start; 0 is replaced by 1.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  1 when err_cnt==0 at done; held until the next start.
- err_cnt  out  16  count of mismatching words; saturates at 16'hFFFF.
- avm_address  out  AW  byte address.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_writedata  out  DW  write data.
- avm_byteenable  out  DW/8  always all ones.
- avm_readdata  in  DW  read data.
- avm_readdatavalid  in  1  read data qualifier.
- avm_waitrequest  in  1  stall.

Behaviour:
- Reset values: busy, done, avm_write, avm_read = 0; pass = 0; err_cnt = 0; address and writedata = 0; FSM in IDLE.
- Sizes: PAGE_WORDS = PAGE_BYTES*8/DW. TOTAL = PAGE_WORDS*PAGE_COUNT. Word index i runs 0..TOTAL-1.
- Addressing for word i: page = i / PAGE_WORDS; address = WIN_BASE + (i % PAGE_WORDS)*DW/8.
- Pattern: 32-bit Galois LFSR, taps 0x80200003, reloaded from seed at the start of each pass. Word i is DW/32 consecutive LFSR states, first state in bits [31:0]. The LFSR advances DW/32 steps per word.
- FSM states: IDLE, WR_PAGE, WR_DATA, RD_PAGE, RD_REQ, RD_WAIT, DONE.
- Fill pass: WR_PAGE is entered only at i==0 and whenever i % PAGE_WORDS == 0.
  - It writes the page number zero-extended to PAGE_REG_ADDR, then goes to WR_DATA.
  - WR_DATA issues one write per word.
  - After the last word, go to RD_PAGE with i=0 if mode==3; otherwise go to DONE.
- Verify pass: RD_PAGE follows the same page-change rule as WR_PAGE. RD_REQ issues the read. RD_WAIT waits for avm_readdatavalid.
  - Exactly one read is outstanding at any time.
  - Compare happens in the readdatavalid cycle; a mismatch increments err_cnt.
- Avalon handshake: a request and its address/data stay stable while avm_waitrequest is high. The request is accepted on the first cycle with waitrequest low, and the FSM advances on that same edge.
- DONE: done=1 for one cycle and pass updated; the next state is IDLE.
- err_cnt clears at an accepted start.
- readdatavalid outside RD_WAIT is ignored.
- A start in the DONE cycle is ignored.
- Reset mid-operation: avm_write and avm_read drop asynchronously and the FSM returns to IDLE. No done pulse is generated.
- Throughput: one write per cycle with no waitrequest, plus one cycle per page change.

Optional Feature:
- Macro: AVMM_FILL_FIRST_ERR_EN.
- When defined, adds three outputs, all cleared at start and at reset:
  - first_err_idx, width $clog2(TOTAL) bits.
  - first_err_exp, DW bits.
  - first_err_act, DW bits.
- These capture the index, expected word and actual word of the first mismatch of a verify pass, and hold until the next start.
- When undefined, these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package avmm_fill_pkg holds:
  - the state enum;
  - mode encodings MODE_FILL, MODE_VERIFY, MODE_BOTH;
  - LFSR_TAPS = 32'h80200003;
  - a function lfsr_next(32b) returning the next state.
- Sub-module avmm_fill_patgen: takes load, seed and adv; outputs a DW-bit word.
  - Internally it unrolls DW/32 LFSR steps per adv.
  - Fill and verify share it.

Test Plan:
- Defaults, mode=1, seed=1, zero-wait slave model -> 4 page writes (data 0..3 to 'h10) and 64 window writes; word 17 goes to 'h1008 after page write 1; done after 68 accepted transfers.
- mode=3, seed='hACE1, memory model -> err_cnt=0, pass=1, 64 reads with a single outstanding read.
- mode=2 after a fill with seed 5, with the memory model corrupting word 33 bit 0 -> err_cnt=1, pass=0. With AVMM_FILL_FIRST_ERR_EN: first_err_idx=33, and exp^act = 64'h1.
- Random waitrequest at 50%, plus readdatavalid latency of 1-7 cycles -> transfers identical to the zero-wait run; address and data stable while stalled.
- rstn low in WR_DATA at word 20 -> avm_write=0 immediately; busy=0, no done. A restart with mode=1 rewrites from page 0.
- start while busy, and seed=0 -> ignored; pattern identical to seed=1.

Source files
------------

// File: rtl/avmm_fill_pkg.sv
// Shared types and helpers for the paged Avalon-MM fill/verify engine.
package avmm_fill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PAGE,
        ST_WR_DATA,
        ST_RD_PAGE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_NOP    = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_VERIFY = 2'd2;
    localparam logic [1:0] MODE_BOTH   = 2'd3;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/avmm_fill_patgen.sv
// Pattern generator: DW/32 consecutive LFSR states per word, lowest lane first.
// Exposes the current word and the word after it so the engine can preload
// registered write data without waiting for the state to advance.
module avmm_fill_patgen
    import avmm_fill_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk_in,
    input  logic          rstn,
    input  logic          load,
    input  logic [31:0]   seed,
    input  logic          adv,
    output logic [DW-1:0] word,
    output logic [DW-1:0] word_nxt
);

    localparam int LANES = DW / 32;

    logic [31:0] state_q, state_d;

    function automatic logic [31:0] lfsr_adv(input logic [31:0] s, input int n);
        logic [31:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = lfsr_next(r);
        return r;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign word[g*32 +: 32]     = lfsr_adv(state_q, g);
        assign word_nxt[g*32 +: 32] = lfsr_adv(state_q, LANES + g);
    end

    // Load wins over advance; a zero seed would lock the LFSR, so it becomes 1.
    always_comb begin
        state_d = state_q;
        if (load)     state_d = (seed == 32'h0) ? 32'h1 : seed;
        else if (adv) state_d = lfsr_adv(state_q, LANES);
    end

    // LFSR state register.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) state_q <= 32'h1;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/avmm_paged_fill_verify.sv
// Avalon-MM master that fills a paged windowed memory with an LFSR pattern,
// reads it back and counts mismatching words.
// Optional first-mismatch capture ports: define AVMM_FILL_FIRST_ERR_EN.
module avmm_paged_fill_verify
    import avmm_fill_pkg::*;
#(
    parameter int DW            = 64,
    parameter int AW            = 16,
    parameter int PAGE_BYTES    = 128,
    parameter int PAGE_COUNT    = 4,
    parameter int PAGE_REG_ADDR = 'h10,
    parameter int WIN_BASE      = 'h1000,
    localparam int PW_L         = PAGE_BYTES * 8 / DW,
    localparam int TOTAL_L      = PW_L * PAGE_COUNT,
    localparam int IW_L         = (TOTAL_L > 1) ? $clog2(TOTAL_L) : 1
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
`ifdef AVMM_FILL_FIRST_ERR_EN
    output logic [IW_L-1:0]   first_err_idx,
    output logic [DW-1:0]     first_err_exp,
    output logic [DW-1:0]     first_err_act,
`endif
    output logic [AW-1:0]     avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [DW-1:0]     avm_writedata,
    output logic [DW/8-1:0]   avm_byteenable,
    input  logic [DW-1:0]     avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
);

    localparam int PWB = (PW_L > 1) ? $clog2(PW_L) : 0;
    localparam int BPW = DW / 8;
    localparam logic [IW_L-1:0] LAST_IDX = IW_L'(TOTAL_L - 1);
    localparam logic [IW_L-1:0] PW_MASK  = IW_L'(PW_L - 1);

    state_t            state_q, state_d;
    logic [IW_L-1:0]   idx_q, idx_d;
    logic [1:0]        mode_q, mode_d;
    logic [31:0]       seed_q, seed_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              wr_q, wr_d, rd_q, rd_d;
`ifdef AVMM_FILL_FIRST_ERR_EN
    logic [IW_L-1:0]   fe_idx_q, fe_idx_d;
    logic [DW-1:0]     fe_exp_q, fe_exp_d, fe_act_q, fe_act_d;
`endif

    logic              pg_load, pg_adv;
    logic [31:0]       pg_seed;
    logic [DW-1:0]     pg_word, pg_word_nxt;
    logic [IW_L-1:0]   idx_nxt;
    logic              is_last, pg_edge, mism;
    logic [15:0]       err_inc;

    // Window address of word i within its page.
    function automatic logic [AW-1:0] win_addr(input logic [IW_L-1:0] i);
        return AW'(WIN_BASE + int'(i & PW_MASK) * BPW);
    endfunction

    // Page number of word i, zero-extended onto the data bus.
    function automatic logic [DW-1:0] page_of(input logic [IW_L-1:0] i);
        return DW'(i >> PWB);
    endfunction

    // Seed comes straight from the port on the start cycle, from the latch later.
    assign pg_seed = (state_q == ST_IDLE) ? seed : seed_q;

    avmm_fill_patgen #(.DW(DW)) u_patgen (
        .clk_in   (clk_in),
        .rstn     (rstn),
        .load     (pg_load),
        .seed     (pg_seed),
        .adv      (pg_adv),
        .word     (pg_word),
        .word_nxt (pg_word_nxt)
    );

    assign idx_nxt = idx_q + IW_L'(1);
    assign is_last = (idx_q == LAST_IDX);
    assign pg_edge = ((idx_nxt & PW_MASK) == '0);
    assign mism    = (avm_readdata != pg_word);
    assign err_inc = (mism && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

    // Next-state logic; every bus output is set up on the edge that enters its state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        pg_load = 1'b0;
        pg_adv  = 1'b0;
`ifdef AVMM_FILL_FIRST_ERR_EN
        fe_idx_d = fe_idx_q;
        fe_exp_d = fe_exp_q;
        fe_act_d = fe_act_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    seed_d  = seed;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    pg_load = 1'b1;
`ifdef AVMM_FILL_FIRST_ERR_EN
                    fe_idx_d = '0;
                    fe_exp_d = '0;
                    fe_act_d = '0;
`endif
                    case (mode)
                        MODE_FILL, MODE_BOTH: begin
                            state_d = ST_WR_PAGE;
                            wr_d    = 1'b1;
                            addr_d  = AW'(PAGE_REG_ADDR);
                            wdata_d = '0;
                        end
                        MODE_VERIFY: begin
                            state_d = ST_RD_PAGE;
                            wr_d    = 1'b1;
                            addr_d  = AW'(PAGE_REG_ADDR);
                            wdata_d = '0;
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_WR_PAGE, ST_RD_PAGE: begin
                if (!avm_waitrequest) begin
                    addr_d = win_addr(idx_q);
                    if (state_q == ST_WR_PAGE) begin
                        state_d = ST_WR_DATA;
                        wdata_d = pg_word;
                    end else begin
                        state_d = ST_RD_REQ;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            ST_WR_DATA: begin
                if (!avm_waitrequest) begin
                    pg_adv = 1'b1;
                    idx_d  = idx_nxt;
                    if (is_last) begin
                        if (mode_q == MODE_BOTH) begin
                            state_d = ST_RD_PAGE;
                            idx_d   = '0;
                            pg_load = 1'b1;
                            addr_d  = AW'(PAGE_REG_ADDR);
                            wdata_d = '0;
                        end else begin
                            state_d = ST_DONE;
                            wr_d    = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_q == 16'd0);
                        end
                    end else if (pg_edge) begin
                        state_d = ST_WR_PAGE;
                        addr_d  = AW'(PAGE_REG_ADDR);
                        wdata_d = page_of(idx_nxt);
                    end else begin
                        addr_d  = win_addr(idx_nxt);
                        wdata_d = pg_word_nxt;
                    end
                end
            end
            ST_RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = ST_RD_WAIT;
                    rd_d    = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    err_d  = err_inc;
                    pg_adv = 1'b1;
                    idx_d  = idx_nxt;
`ifdef AVMM_FILL_FIRST_ERR_EN
                    if (mism && err_q == 16'd0) begin
                        fe_idx_d = idx_q;
                        fe_exp_d = pg_word;
                        fe_act_d = avm_readdata;
                    end
`endif
                    if (is_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_inc == 16'd0);
                    end else if (pg_edge) begin
                        state_d = ST_RD_PAGE;
                        wr_d    = 1'b1;
                        addr_d  = AW'(PAGE_REG_ADDR);
                        wdata_d = page_of(idx_nxt);
                    end else begin
                        state_d = ST_RD_REQ;
                        rd_d    = 1'b1;
                        addr_d  = win_addr(idx_nxt);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Engine state and registered outputs; reset drops requests immediately.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mode_q  <= MODE_NOP;
            seed_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
`ifdef AVMM_FILL_FIRST_ERR_EN
            fe_idx_q <= '0;
            fe_exp_q <= '0;
            fe_act_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
`ifdef AVMM_FILL_FIRST_ERR_EN
            fe_idx_q <= fe_idx_d;
            fe_exp_q <= fe_exp_d;
            fe_act_q <= fe_act_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign avm_address    = addr_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
`ifdef AVMM_FILL_FIRST_ERR_EN
    assign first_err_idx  = fe_idx_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_act  = fe_act_q;
`endif

endmodule

// File: tb/tb_avmm_paged_fill_verify.sv
// Bench for avmm_paged_fill_verify: paged memory slave with random stalls and
// read latency, transfer log compared against a list built from the pattern rules.
module tb_avmm_paged_fill_verify;

    localparam int DW = 64, AW = 16, PAGE_BYTES = 128, PAGE_COUNT = 4;
    localparam int PAGE_REG = 'h10, WIN_BASE = 'h1000;
    localparam int PW = PAGE_BYTES * 8 / DW, TOTAL = PW * PAGE_COUNT, IW = $clog2(TOTAL);
    localparam logic [31:0] TAPS = 32'h80200003;

    logic clk_in = 0, rstn = 0, start = 0;
    logic [1:0] mode = 0;
    logic [31:0] seed = 0;
    logic busy, done, pass;
    logic [15:0] err_cnt;
    logic [AW-1:0] avm_address;
    logic avm_write, avm_read;
    logic [DW-1:0] avm_writedata, avm_readdata = '0;
    logic [DW/8-1:0] avm_byteenable;
    logic avm_readdatavalid = 0, avm_waitrequest = 0;
`ifdef AVMM_FILL_FIRST_ERR_EN
    logic [IW-1:0] first_err_idx;
    logic [DW-1:0] first_err_exp, first_err_act;
`endif

    avmm_paged_fill_verify #(.DW(DW), .AW(AW), .PAGE_BYTES(PAGE_BYTES), .PAGE_COUNT(PAGE_COUNT),
                             .PAGE_REG_ADDR(PAGE_REG), .WIN_BASE(WIN_BASE)) dut (
        .clk_in(clk_in), .rstn(rstn), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
`ifdef AVMM_FILL_FIRST_ERR_EN
        .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_act(first_err_act),
`endif
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } xfer_t;
    typedef struct { logic [DW-1:0] data; int cnt; } rsp_t;
    typedef struct {
        logic [1:0] mode; logic [31:0] seed; int cidx; logic [DW-1:0] cmask;
        int wait_pct; int lat_max; int spur_pct; int exp_cycles; int exp_err;
        int bstart; bit dstart;
    } row_t;

    int n_pass = 0, n_tot = 0;

    // slave knobs
    int wait_pct = 0, lat_max = 1, spur_pct = 0, corrupt_idx = -1;
    logic [DW-1:0] corrupt_mask = '0;

    // slave state
    logic [DW-1:0] mem [TOTAL];
    int page_reg = 0;
    xfer_t act_q[$];
    rsp_t rsp_q[$];
    bit plan_v = 0, plan_we = 0;
    logic [AW-1:0] plan_addr;
    logic [DW-1:0] plan_data;
    bit st_v = 0, st_we = 0, st_rd = 0;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    int stall_err = 0, outst_err = 0;

    // reference model
    logic [DW-1:0] ref_mem [TOTAL];
    logic [DW-1:0] pat [TOTAL];
    xfer_t exp_q[$];
    int m_err, m_first;
    logic [DW-1:0] m_fexp, m_fact;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    // Expected transfer list, error count and first mismatch for one operation.
    task automatic build_exp(input logic [1:0] md, input logic [31:0] sd, input int cidx, input logic [DW-1:0] cm);
        logic [31:0] s;
        logic [DW-1:0] rdv;
        exp_q.delete();
        m_err = 0; m_first = 0; m_fexp = '0; m_fact = '0;
        s = (sd == 0) ? 32'h1 : sd;
        for (int i = 0; i < TOTAL; i++)
            for (int k = 0; k < DW / 32; k++) begin
                pat[i][32*k +: 32] = s;
                s = lstep(s);
            end
        if (md[0])
            for (int i = 0; i < TOTAL; i++) begin
                if (i % PW == 0) exp_q.push_back('{1'b1, AW'(PAGE_REG), DW'(i / PW)});
                exp_q.push_back('{1'b1, AW'(WIN_BASE + (i % PW) * (DW / 8)), pat[i]});
                ref_mem[i] = pat[i];
            end
        if (md[1])
            for (int i = 0; i < TOTAL; i++) begin
                if (i % PW == 0) exp_q.push_back('{1'b1, AW'(PAGE_REG), DW'(i / PW)});
                rdv = ref_mem[i] ^ ((i == cidx) ? cm : '0);
                exp_q.push_back('{1'b0, AW'(WIN_BASE + (i % PW) * (DW / 8)), rdv});
                if (rdv != pat[i]) begin
                    if (m_err == 0) begin m_first = i; m_fexp = pat[i]; m_fact = rdv; end
                    m_err++;
                end
            end
    endtask

    // Paged memory slave; everything is decided on the falling edge. A request
    // seen unstalled here is accepted on the next rising edge and logged one
    // falling edge later, so a reset in between cancels it.
    always @(negedge clk_in) begin
        int widx;
        if (!rstn) begin
            plan_v = 0; st_v = 0; rsp_q.delete();
            avm_readdatavalid = 0; avm_waitrequest = 0;
        end else begin
            if (st_v && (avm_write !== st_we || avm_read !== st_rd || avm_address !== st_addr ||
                         (st_we && avm_writedata !== st_data))) stall_err++;
            st_v = 0;
            if (plan_v) begin
                widx = page_reg * PW + (int'(plan_addr) - WIN_BASE) / (DW / 8);
                if (plan_we) begin
                    act_q.push_back('{1'b1, plan_addr, plan_data});
                    if (int'(plan_addr) == PAGE_REG) page_reg = int'(plan_data);
                    else if (widx >= 0 && widx < TOTAL) mem[widx] = plan_data;
                end else begin
                    logic [DW-1:0] d;
                    if (rsp_q.size() != 0) outst_err++;
                    d = (widx >= 0 && widx < TOTAL) ? mem[widx] : '0;
                    if (widx == corrupt_idx) d = d ^ corrupt_mask;
                    act_q.push_back('{1'b0, plan_addr, d});
                    rsp_q.push_back('{d, int'($urandom_range(lat_max, 1))});
                end
                plan_v = 0;
            end
            avm_readdatavalid = 0;
            if (rsp_q.size() != 0) begin
                if (rsp_q[0].cnt <= 1) begin
                    avm_readdata = rsp_q[0].data; avm_readdatavalid = 1;
                    void'(rsp_q.pop_front());
                end else rsp_q[0].cnt--;
            end else if (int'($urandom_range(99)) < spur_pct) begin
                avm_readdata = {$urandom, $urandom}; avm_readdatavalid = 1;
            end
            avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
            if (avm_write || avm_read) begin
                if (avm_waitrequest) begin
                    st_v = 1; st_we = avm_write; st_rd = avm_read; st_addr = avm_address; st_data = avm_writedata;
                end else begin
                    plan_v = 1; plan_we = avm_write; plan_addr = avm_address; plan_data = avm_writedata;
                end
            end
        end
    end

    task automatic run_op(input int r, input row_t t);
        int cyc, bad;
        bit got, busy_seen;
        wait_pct = t.wait_pct; lat_max = t.lat_max; spur_pct = t.spur_pct;
        corrupt_idx = t.cidx; corrupt_mask = t.cmask;
        build_exp(t.mode, t.seed, t.cidx, t.cmask);
        @(negedge clk_in);
        act_q.delete(); stall_err = 0; outst_err = 0;
        start = 1; mode = t.mode; seed = t.seed;
        cyc = 0; got = 0; busy_seen = 0;
        while (!got && cyc < 4000) begin
            @(negedge clk_in);
            start = 0; cyc++;
            if (cyc == 1) busy_seen = busy;
            if (cyc == t.bstart) begin start = 1; mode = 2'd2; seed = 32'h77; end
            if (done) got = 1;
        end
        chk($sformatf("r%0d_done_seen", r), got, 1'b1);
        chk($sformatf("r%0d_busy_after_start", r), busy_seen, 1'b1);
        if (t.exp_cycles > 0) chk($sformatf("r%0d_cycles", r), cyc, t.exp_cycles);
        chk($sformatf("r%0d_err_cnt", r), err_cnt, (t.exp_err >= 0) ? t.exp_err : m_err);
        chk($sformatf("r%0d_pass", r), pass, (t.exp_err >= 0) ? (t.exp_err == 0) : (m_err == 0));
`ifdef AVMM_FILL_FIRST_ERR_EN
        chk($sformatf("r%0d_first_idx", r), first_err_idx, m_first);
        chk($sformatf("r%0d_first_exp", r), first_err_exp, m_fexp);
        chk($sformatf("r%0d_first_act", r), first_err_act, m_fact);
`endif
        if (t.dstart) begin start = 1; mode = 2'd1; end
        @(negedge clk_in);
        start = 0;
        chk($sformatf("r%0d_done_pulse", r), {done, busy}, 2'b00);
        @(negedge clk_in);
        chk($sformatf("r%0d_idle_after", r), {busy, avm_write, avm_read}, 3'b000);
        chk($sformatf("r%0d_xfer_count", r), act_q.size(), exp_q.size());
        bad = -1;
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++)
            if (bad < 0 && (act_q[k].we !== exp_q[k].we || act_q[k].addr !== exp_q[k].addr ||
                            act_q[k].data !== exp_q[k].data)) bad = k;
        n_tot++;
        if (bad < 0) n_pass++;
        else $display("FAIL r%0d_xfer[%0d]: got we=%0d a=%0h d=%0h expected we=%0d a=%0h d=%0h", r, bad,
                      act_q[bad].we, act_q[bad].addr, act_q[bad].data,
                      exp_q[bad].we, exp_q[bad].addr, exp_q[bad].data);
        chk($sformatf("r%0d_stall_stable", r), stall_err, 0);
        chk($sformatf("r%0d_one_outstanding", r), outst_err, 0);
    endtask

    function automatic row_t mk(input logic [1:0] md, input logic [31:0] sd, input int ci,
                                input logic [DW-1:0] cm, input int wp, input int lm, input int sp,
                                input int ec, input int ee, input int bs, input bit ds);
        row_t t;
        t.mode = md; t.seed = sd; t.cidx = ci; t.cmask = cm; t.wait_pct = wp; t.lat_max = lm;
        t.spur_pct = sp; t.exp_cycles = ec; t.exp_err = ee; t.bstart = bs; t.dstart = ds;
        return t;
    endfunction

    row_t tbl [11];

    initial begin
        logic [DW-1:0] sh;
        int cyc;
        bit bad_done;
        for (int i = 0; i < TOTAL; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        //          mode  seed        cidx mask   wait lat spur cyc  err bstart dstart
        tbl[0] = mk(2'd1, 32'h1,      -1,  '0,    0,   1,  0,   69,  0,  0,  0);
        tbl[1] = mk(2'd3, 32'hACE1,   -1,  '0,    0,   1,  0,   201, 0,  0,  0);
        tbl[2] = mk(2'd1, 32'h5,      -1,  '0,    0,   1,  0,   69,  0,  0,  0);
        tbl[3] = mk(2'd2, 32'h5,      33,  64'h1, 0,   1,  0,   133, 1,  0,  0);
        tbl[4] = mk(2'd2, 32'h6,      -1,  '0,    50,  7,  20,  0,   -1, 0,  0);
        tbl[5] = mk(2'd0, 32'h9,      -1,  '0,    0,   1,  0,   1,   0,  0,  1);
        tbl[6] = mk(2'd1, 32'h0,      -1,  '0,    0,   1,  0,   69,  0,  10, 1);
        for (int r = 7; r < 11; r++) begin
            sh = 64'h1 << $urandom_range(DW - 1);
            tbl[r] = mk(2'd3, $urandom, (r % 2) ? int'($urandom_range(TOTAL - 1)) : -1, sh,
                        50, 7, 20, 0, -1, 0, 0);
        end

        // reset state
        #1;
        chk("rst_busy_done_pass", {busy, done, pass}, 3'b000);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_wr_rd", {avm_write, avm_read}, 2'b00);
        chk("rst_address", avm_address, '0);
        chk("rst_writedata", avm_writedata, '0);
        chk("byteenable", avm_byteenable, 8'hFF);
        repeat (3) @(negedge clk_in);
        rstn = 1;

        for (int r = 0; r < 11; r++) run_op(r, tbl[r]);

        // reset while word 20 is on the bus
        wait_pct = 0; lat_max = 1; spur_pct = 0; corrupt_idx = -1;
        build_exp(2'd1, 32'h9, -1, '0);
        @(negedge clk_in);
        start = 1; mode = 2'd1; seed = 32'h9;
        for (cyc = 1; cyc <= 23; cyc++) begin @(negedge clk_in); start = 0; end
        chk("rst_mid_word20_addr", {avm_write, avm_address}, {1'b1, AW'(WIN_BASE + 4 * (DW / 8))});
        chk("rst_mid_word20_data", avm_writedata, pat[20]);
        #2 rstn = 0;
        #1;
        chk("rst_mid_write_drop", {avm_write, avm_read}, 2'b00);
        chk("rst_mid_busy", busy, 1'b0);
        bad_done = 0;
        repeat (3) begin @(negedge clk_in); if (done || busy) bad_done = 1; end
        chk("rst_mid_no_done", bad_done, 1'b0);
        rstn = 1;
        run_op(11, mk(2'd1, 32'h1, -1, '0, 0, 1, 0, 69, 0, 0, 0));
        run_op(12, mk(2'd2, 32'h1, 5, 64'h8000_0000_0000_0000, 50, 7, 20, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
